// File: rtl/ram_fill_check.sv
// RAM fill / verify sweeper.
// Writes seed+k to every address k of an external RAM. In verify mode it then
// reads every word back and stops at the first word that differs.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, mode, seed   - command: start pulse, 0=fill / 1=fill+verify, base pattern
//   busy, done          - sweep in progress, one-cycle completion pulse
//   error, err_adr,
//   err_data            - first verify mismatch (flag, address, word read)
//   mem_adr, mem_data,
//   mem_load, mem_out   - RAM port (mem_out is a combinational read of mem_adr)
module ram_fill_check #(
    parameter int unsigned ADR_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [15:0]      seed,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [ADR_W-1:0] err_adr,
    output logic [15:0]      err_data,
    output logic [ADR_W-1:0] mem_adr,
    output logic [15:0]      mem_data,
    output logic             mem_load,
    input  logic [15:0]      mem_out
);

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADR_W-1:0]    adr_d;
    logic [DATA_W-1:0]   data_d;
    logic                load_d, busy_d, done_d;
    logic                error_d;
    logic [ADR_W-1:0]    err_adr_d;
    logic [DATA_W-1:0]   err_data_d;
    logic                last_adr;
    logic [DATA_W-1:0]   expected;

    // Pattern word for the address currently presented to the RAM.
    assign expected = seed_q + DATA_W'(mem_adr);
    assign last_adr = &mem_adr;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            seed_q   <= '0;
            mem_adr  <= '0;
            mem_data <= '0;
            mem_load <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_adr  <= '0;
            err_data <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            seed_q   <= seed_d;
            mem_adr  <= adr_d;
            mem_data <= data_d;
            mem_load <= load_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            err_adr  <= err_adr_d;
            err_data <= err_data_d;
        end
    end

    // Next state; outputs are derived from the next state so they register
    // in step with it.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        seed_d     = seed_q;
        adr_d      = '0;
        error_d    = error;
        err_adr_d  = err_adr;
        err_data_d = err_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WRITE;
                    mode_d     = mode;
                    seed_d     = seed;
                    error_d    = 1'b0;
                    err_adr_d  = '0;
                    err_data_d = '0;
                end
            end
            WRITE: begin
                if (last_adr) begin
                    state_d = mode_q ? READ : DONE;
                end else begin
                    adr_d = mem_adr + ADR_W'(1);
                end
            end
            READ: begin
                if (mem_out != expected) begin
                    state_d    = DONE;
                    error_d    = 1'b1;
                    err_adr_d  = mem_adr;
                    err_data_d = mem_out;
                end else if (last_adr) begin
                    state_d = DONE;
                end else begin
                    adr_d = mem_adr + ADR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load_d = (state_d == WRITE);
        busy_d = (state_d == WRITE) || (state_d == READ);
        done_d = (state_d == DONE);
        data_d = load_d ? (seed_d + DATA_W'(adr_d)) : '0;
    end

endmodule

// File: tb/tb_ram_fill_check.sv
// Randomized self-checking bench for ram_fill_check with a behavioural RAM.
module tb_ram_fill_check;

    localparam int unsigned ADR_W = 9;
    localparam int unsigned DEPTH = 1 << ADR_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             mode;
    logic [15:0]      seed;
    logic             busy;
    logic             done;
    logic             error;
    logic [ADR_W-1:0] err_adr;
    logic [15:0]      err_data;
    logic [ADR_W-1:0] mem_adr;
    logic [15:0]      mem_data;
    logic             mem_load;
    logic [15:0]      mem_out;

    logic [15:0]      ram [DEPTH];
    logic             fault_en;
    logic [ADR_W-1:0] fault_adr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_fill_check #(.ADR_W(ADR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .seed     (seed),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_adr  (err_adr),
        .err_data (err_data),
        .mem_adr  (mem_adr),
        .mem_data (mem_data),
        .mem_load (mem_load),
        .mem_out  (mem_out)
    );

    // Behavioural RAM with optional bit-0 fault on reads of one address.
    always @(posedge clk) begin
        if (mem_load) ram[mem_adr] <= mem_data;
    end
    assign mem_out = ram[mem_adr] ^ {15'd0, (fault_en && !mem_load && busy && mem_adr == fault_adr)};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command; glitch>=0 pulses start (with other args) at that cycle of the sweep.
    task automatic run_sweep(input logic m, input logic [15:0] s, input logic f,
                             input int k, input int glitch);
        int exp_lat, lat, busy_cnt, load_cnt, bad_load, bad_words;
        logic [15:0] w;
        fault_en  = f;
        fault_adr = ADR_W'(k);
        // Reference: plain arithmetic from the sweep rules.
        if (!m)     exp_lat = DEPTH + 1;
        else if (f) exp_lat = DEPTH + k + 2;
        else        exp_lat = 2 * DEPTH + 1;
        @(negedge clk);
        start = 1'b1; mode = m; seed = s;
        @(posedge clk);
        lat = 0; busy_cnt = 0; load_cnt = 0; bad_load = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            @(negedge clk);
            start = (i == glitch);
            mode  = ~m;
            seed  = 16'($urandom);
            if (busy) busy_cnt++;
            if (mem_load) load_cnt++;
            if (mem_load && mem_data !== 16'(s + 16'(mem_adr))) bad_load++;
            if (mem_load && !busy) bad_load++;
            if (done) begin
                lat = i + 1;
                break;
            end
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        check("write_cycles", 32'(load_cnt), 32'(DEPTH));
        check("write_data", 32'(bad_load), 32'd0);
        check("error", 32'(error), 32'(m && f));
        check("err_adr", 32'(err_adr), (m && f) ? 32'(k) : 32'd0);
        w = 16'(s + 16'(k)) ^ 16'd1;
        check("err_data", 32'(err_data), (m && f) ? 32'(w) : 32'd0);
        @(negedge clk);
        check("done_pulse", {30'd0, done, busy}, 32'd0);
        check("idle_outputs", {7'd0, mem_load, mem_data, 7'd0, mem_adr}, 32'd0);
        check("err_hold", 32'(error), 32'(m && f));
        bad_words = 0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            w = s + 16'(a);
            if (ram[a] !== w) bad_words++;
        end
        check("ram_contents", 32'(bad_words), 32'd0);
        fault_en = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0; mode = 1'b0; seed = '0;
        fault_en = 1'b0; fault_adr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, done, error, mem_load, 28'd0}, 32'd0);
        check("reset_bus", {7'd0, mem_adr, mem_data}, 32'd0);
        check("reset_err", {7'd0, err_adr, err_data}, 32'd0);
        reset = 1'b0;

        run_sweep(1'b0, 16'h1234, 1'b0, 0, 100);
        check("word5", 32'(ram[5]), 32'h1239);
        check("word511", 32'(ram[511]), 32'h1433);
        run_sweep(1'b1, 16'hA5A5, 1'b0, 0, 700);
        run_sweep(1'b1, 16'h0000, 1'b1, 100, -1);
        check("fault_err_data", 32'(err_data), 32'h0065);
        run_sweep(1'b1, 16'hFFFF, 1'b0, 0, -1);
        check("wrap0", 32'(ram[0]), 32'hFFFF);
        check("wrap1", 32'(ram[1]), 32'h0000);
        check("wrap511", 32'(ram[511]), 32'h01FE);
        run_sweep(1'b1, 16'h0100, 1'b1, 0, -1);
        run_sweep(1'b1, 16'h0200, 1'b1, 511, -1);

        for (int r = 0; r < 6; r++) begin
            run_sweep(1'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, DEPTH - 1)),
                      int'($urandom_range(0, 900)));
        end

        // Reset in the middle of the write phase.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; seed = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (mem_adr != ADR_W'(200) && guard < 2 * DEPTH) begin
            @(negedge clk);
            guard++;
        end
        check("reach_adr200", 32'(mem_adr), 32'd200);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_state", {busy, mem_load, done, 29'd0}, 32'd0);
        check("abort_adr", 32'(mem_adr), 32'd0);
        guard = 0;
        for (int i = 0; i < 2 * int'(DEPTH) + 4; i++) begin
            @(negedge clk);
            if (done || mem_load || busy) guard++;
        end
        check("abort_quiet", 32'(guard), 32'd0);

        // start together with reset is ignored.
        start = 1'b1; reset = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        check("start_with_reset", {busy, mem_load, done, 29'd0}, 32'd0);
        repeat (3) @(negedge clk);
        check("still_idle", {busy, mem_load, done, 29'd0}, 32'd0);

        run_sweep(1'b0, 16'hBEEF, 1'b0, 0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
